// File: rtl/alu_writeback.sv
// ALU writeback stage: registers one ALU result per cycle into the register
// file and the flag register. A multiply with writeback spends a second
// cycle writing its high byte to dest_reg+1, which wraps modulo the
// register-file size.

`ifndef ALU_MULTIPLY
`define ALU_MULTIPLY 4'hA
`endif

module alu_writeback #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter logic [3:0]  MUL_CMND   = `ALU_MULTIPLY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            cmnd,
    input  logic [15:0]           result,
    input  logic [2:0]            flags,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    input  logic                  wb_en,
    input  logic                  flag_en,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [7:0]            rf_wdata,
    output logic [2:0]            flags_q,
    output logic                  busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] MUL_HI = 1'b1;

    logic [0:0]            state;
    logic [7:0]            hi_data;
    logic [REG_ADDR_W-1:0] hi_addr;
    logic                  accept;

    // Handshake and status are decoded from state alone
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == MUL_HI);
        accept   = in_valid && (state == IDLE);
    end

    // Capture results, drive the registered write port and the pending high byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flags_q  <= '0;
            hi_data  <= '0;
            hi_addr  <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rf_we    <= wb_en;
                        rf_waddr <= dest_reg;
                        rf_wdata <= result[7:0];
                        if (flag_en) begin
                            flags_q <= flags;
                        end
                        if ((cmnd == MUL_CMND) && wb_en) begin
                            hi_data <= result[15:8];
                            hi_addr <= dest_reg + REG_ADDR_W'(1);
                            state   <= MUL_HI;
                        end
                    end
                end
                MUL_HI: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= hi_addr;
                    rf_wdata <= hi_data;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a table of single-cycle instructions
// applied back-to-back, plus hand-written multiply, stall and reset sequences.

module tb_alu_writeback;

    localparam int unsigned AW = 3;
    localparam logic [3:0] C_ADD = 4'h1;
    localparam logic [3:0] C_SUB = 4'h2;
    localparam logic [3:0] C_AND = 4'h3;
    localparam logic [3:0] C_CMP = 4'h4;
    localparam logic [3:0] C_MUL = 4'hA;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    cmnd;
    logic [15:0]   result;
    logic [2:0]    flags;
    logic [AW-1:0] dest_reg;
    logic          wb_en;
    logic          flag_en;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [7:0]    rf_wdata;
    logic [2:0]    flags_q;
    logic          busy;

    int checks = 0;
    int errors = 0;

    alu_writeback #(.REG_ADDR_W(AW), .MUL_CMND(C_MUL)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cmnd     (cmnd),
        .result   (result),
        .flags    (flags),
        .dest_reg (dest_reg),
        .wb_en    (wb_en),
        .flag_en  (flag_en),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .flags_q  (flags_q),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    cmnd;
        logic [15:0]   result;
        logic [2:0]    flags;
        logic [AW-1:0] dest;
        logic          wb_en;
        logic          flag_en;
        logic          exp_we;
        logic [AW-1:0] exp_waddr;
        logic [7:0]    exp_wdata;
        logic [2:0]    exp_flags;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [15:0] r,
                         input logic [2:0] f, input logic [AW-1:0] d,
                         input logic we, input logic fe);
        in_valid = v;
        cmnd     = c;
        result   = r;
        flags    = f;
        dest_reg = d;
        wb_en    = we;
        flag_en  = fe;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          cmnd   result    flags   dst wb fe  we addr data   flags_q
        vecs[0] = '{C_ADD, 16'h0042, 3'b000, 2, 1, 1,  1, 2, 8'h42, 3'b000};
        vecs[1] = '{C_SUB, 16'h0005, 3'b010, 3, 1, 1,  1, 3, 8'h05, 3'b010};
        vecs[2] = '{C_CMP, 16'h00FF, 3'b001, 5, 0, 1,  0, 5, 8'hFF, 3'b001};
        vecs[3] = '{C_AND, 16'h0001, 3'b100, 1, 1, 0,  1, 1, 8'h01, 3'b001};
        vecs[4] = '{C_AND, 16'h0002, 3'b111, 2, 1, 0,  1, 2, 8'h02, 3'b001};
        vecs[5] = '{C_AND, 16'h0003, 3'b000, 3, 1, 0,  1, 3, 8'h03, 3'b001};
        vecs[6] = '{C_MUL, 16'hAB12, 3'b110, 4, 0, 1,  0, 4, 8'h12, 3'b110};
        vecs[7] = '{C_ADD, 16'h12FF, 3'b100, 7, 1, 1,  1, 7, 8'hFF, 3'b100};

        drive(0, 4'h0, 16'h0, 3'b0, '0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_we", 32'(rf_we), 0);
        chk("reset_waddr", 32'(rf_waddr), 0);
        chk("reset_wdata", 32'(rf_wdata), 0);
        chk("reset_flags", 32'(flags_q), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(in_ready), 1);
        reset = 1'b1;

        // Table: one instruction per cycle, no gaps
        for (int i = 0; i < 8; i++) begin
            drive(1, vecs[i].cmnd, vecs[i].result, vecs[i].flags, vecs[i].dest,
                  vecs[i].wb_en, vecs[i].flag_en);
            @(negedge clk);
            chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].exp_waddr));
                chk($sformatf("v%0d_wdata", i), 32'(rf_wdata), 32'(vecs[i].exp_wdata));
            end
            chk($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vecs[i].exp_flags));
            chk($sformatf("v%0d_busy", i), 32'(busy), 0);
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 1);
        end

        drive(0, 4'h0, 16'h0, 3'b0, '0, 0, 0);
        @(negedge clk);
        chk("idle_we", 32'(rf_we), 0);
        chk("idle_hold_waddr", 32'(rf_waddr), 7);
        chk("idle_hold_wdata", 32'(rf_wdata), 8'hFF);
        chk("idle_hold_flags", 32'(flags_q), 3'b100);

        // Multiply to R7 with address wrap, SUB held valid through the stall
        drive(1, C_MUL, 16'h1E78, 3'b000, 7, 1, 1);
        @(negedge clk);
        chk("mul_lo_we", 32'(rf_we), 1);
        chk("mul_lo_waddr", 32'(rf_waddr), 7);
        chk("mul_lo_wdata", 32'(rf_wdata), 8'h78);
        chk("mul_lo_ready", 32'(in_ready), 0);
        chk("mul_lo_busy", 32'(busy), 1);
        chk("mul_lo_flags", 32'(flags_q), 3'b000);
        drive(1, C_SUB, 16'h0005, 3'b011, 3, 1, 1);
        @(negedge clk);
        chk("mul_hi_we", 32'(rf_we), 1);
        chk("mul_hi_waddr", 32'(rf_waddr), 0);
        chk("mul_hi_wdata", 32'(rf_wdata), 8'h1E);
        chk("mul_hi_ready", 32'(in_ready), 1);
        chk("mul_hi_busy", 32'(busy), 0);
        chk("mul_hi_flags", 32'(flags_q), 3'b000);
        @(negedge clk);
        chk("sub_we", 32'(rf_we), 1);
        chk("sub_waddr", 32'(rf_waddr), 3);
        chk("sub_wdata", 32'(rf_wdata), 8'h05);
        chk("sub_flags", 32'(flags_q), 3'b011);
        drive(0, 4'h0, 16'h0, 3'b0, '0, 0, 0);
        @(negedge clk);
        chk("post_sub_we", 32'(rf_we), 0);

        // Plain multiply: third cycle has no write
        drive(1, C_MUL, 16'h1E78, 3'b000, 7, 1, 0);
        @(negedge clk);
        drive(0, 4'h0, 16'h0, 3'b0, '0, 0, 0);
        @(negedge clk);
        chk("mul2_hi_waddr", 32'(rf_waddr), 0);
        @(negedge clk);
        chk("mul2_done_we", 32'(rf_we), 0);
        chk("mul2_done_ready", 32'(in_ready), 1);

        // Reset pulsed while the high byte is pending
        drive(1, C_MUL, 16'h3456, 3'b101, 5, 1, 1);
        @(negedge clk);
        drive(0, 4'h0, 16'h0, 3'b0, '0, 0, 0);
        chk("rst_pre_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_we", 32'(rf_we), 0);
        chk("rst_async_waddr", 32'(rf_waddr), 0);
        chk("rst_async_wdata", 32'(rf_wdata), 0);
        chk("rst_async_flags", 32'(flags_q), 0);
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d_we", k), 32'(rf_we), 0);
            chk($sformatf("rst_after%0d_busy", k), 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: REG_ADDR_W, default 3, width of the register-file write address (8 GP registers).
REQ-002 Parameter: MUL_CMND, default `ALU_MULTIPLY (constants.sv), cmnd code that selects the two-byte writeback.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; clears all state while 0.
REQ-005 in_valid  input  1  ALU result on this cycle is a real instruction.
REQ-006 in_ready  output  1  block can accept a result this cycle.
REQ-007 cmnd  input  4  ALU command code of the instruction.
REQ-008 result  input  16  ALU result; bits 15:8 meaningful only for MUL_CMND.
REQ-009 flags  input  3  ALU flags (ZERO, CARRY, NEG, bit positions per constants.sv).
REQ-010 dest_reg  input  REG_ADDR_W  destination GP register.
REQ-011 wb_en  input  1  instruction writes a register (0 = flags-only, e.g. compare).
REQ-012 flag_en  input  1  instruction updates the flag register.
REQ-013 rf_we  output  1  register-file write strobe.
REQ-014 rf_waddr  output  REG_ADDR_W  register-file write address.
REQ-015 rf_wdata  output  8  register-file write data.
REQ-016 flags_q  output  3  architectural flag register.
REQ-017 busy  output  1  high while the multiply high byte is pending.

Function
REQ-018 Accept: capture occurs on a rising edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 is ignored (no capture, no side effect).
REQ-019 in_ready = 1 in IDLE, 0 in MUL_HI; combinational from state only.
REQ-020 FSM states: IDLE, MUL_HI; reset state IDLE.
REQ-021 IDLE, accept, cmnd != MUL_CMND: next cycle rf_we = wb_en, rf_waddr = dest_reg, rf_wdata = result[7:0]; stay IDLE.
REQ-022 IDLE, accept, cmnd == MUL_CMND, wb_en=1: next cycle rf_we=1, rf_waddr=dest_reg, rf_wdata=result[7:0]; store result[15:8] and (dest_reg+1) mod 2^REG_ADDR_W; go to MUL_HI.
REQ-023 MUL_HI (exactly one cycle): next cycle rf_we=1, rf_waddr=stored address, rf_wdata=stored high byte; return to IDLE.
REQ-024 Multiply with wb_en=0: no register write, no MUL_HI entry.
REQ-025 Address wrap: dest_reg = 2^REG_ADDR_W-1 sends the high byte to register 0.
REQ-026 rf_we, rf_waddr, rf_wdata are registered outputs; latency accept -> first write = 1 cycle; multiply occupies 2 consecutive write cycles.
REQ-027 rf_we = 0 on every cycle with no write scheduled; rf_waddr/rf_wdata hold last value.
REQ-028 flags_q loads flags on the accept edge when flag_en=1; otherwise holds; never changed by MUL_HI cycle.
REQ-029 busy = 1 exactly in MUL_HI.
REQ-030 Back-to-back: IDLE accepts on consecutive cycles, one write per cycle, no bubble.

Reset
REQ-031 reset=0 asynchronously forces: state IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, flags_q=0, busy=0, stored high byte/address = 0.
REQ-032 Reset asserted in MUL_HI aborts the pending high-byte write; it is never issued after release.
REQ-033 First accept possible on the first rising edge with reset=1.

Verification
REQ-034 ADD, result=16'h0042, dest_reg=2, wb_en=1, flag_en=1, flags=3'b000 -> next cycle rf_we=1, rf_waddr=2, rf_wdata=8'h42, flags_q=0.
REQ-035 MUL, result=16'h1E78, dest_reg=7 -> cycle+1 write R7=8'h78; in_ready=0, busy=1; cycle+2 write R0=8'h1E; cycle+3 rf_we=0, in_ready=1.
REQ-036 in_valid held high across MUL then SUB (result 8'h05, dest 3) -> SUB not captured during MUL_HI; captured next IDLE cycle, written R3=8'h05 at cycle+3.
REQ-037 Compare: wb_en=0, flag_en=1, flags=ZERO set -> rf_we stays 0, flags_q ZERO bit = 1.
REQ-038 reset pulsed low during MUL_HI -> all outputs 0 immediately, no high-byte write after release, in_ready=1.
REQ-039 Three back-to-back ANDs to R1,R2,R3 -> three consecutive rf_we=1 cycles with matching addresses/data; flag_en=0 leaves flags_q unchanged.
